// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB3 completer register file.
// Offsets are byte addresses; the decoder works on word indices.
package apb_regfile_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int ID_OFS       = 0;
    localparam int WAIT_OFS     = 4;
    localparam int ERRCNT_OFS   = 8;
    localparam int SCRATCH_BASE = 12;

    localparam int WAIT_W   = 4;
    localparam int ERRCNT_W = 8;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

    function automatic int word_idx(input int byte_ofs);
        return byte_ofs / 4;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between the master and this completer.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile_wait_timer.sv
// Wait-state down-counter. o_done flags the edge at which the count reaches
// zero, so a load of 0 completes at the load edge itself.
module apb_wait_timer
    import apb_regfile_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);
    logic [W-1:0] r_count;

    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign o_done = i_load ? (i_load_val == '0) : (i_en && r_count == W'(1));
endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer: ID, WAIT_CFG, saturating ERR_CNT and scratch registers,
// with run-time programmable wait states and registered PREADY/PRDATA/PSLVERR.
module apb_slave_regfile
    import apb_regfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_VALUE_DEFAULT)
) (
    input logic               PCLK,
    input logic               PRESETn,
    apb_slave_regfile_if.slave apb
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int IDXF_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] ID_IDX      = IDX_W'(word_idx(ID_OFS));
    localparam logic [IDX_W-1:0] WAIT_IDX    = IDX_W'(word_idx(WAIT_OFS));
    localparam logic [IDX_W-1:0] ERRCNT_IDX  = IDX_W'(word_idx(ERRCNT_OFS));
    localparam int               SCRATCH_IDX = word_idx(SCRATCH_BASE);

    state_e                r_state, w_state_nxt;
    logic                  w_setup, w_tick, w_commit, w_abort, w_tmr_done;
    logic [IDXF_W-1:0]     w_idx_full;
    logic [IDX_W-1:0]      w_idx, r_idx;
    logic                  w_err_dec, r_err, r_write;
    logic [DATA_WIDTH-1:0] w_reg_rd, w_rdata_dec, r_rdata, r_wdata;
    logic                  r_pready, r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [WAIT_W-1:0]     r_wait_cfg;
    logic [ERRCNT_W-1:0]   r_err_cnt;
    logic [DATA_WIDTH-1:0] r_scratch [SCRATCH_IDX:NUM_REGS-1];

    // Address decode during the setup phase
    assign w_idx_full = apb.PADDR[ADDR_WIDTH-1:2];
    assign w_idx      = w_idx_full[IDX_W-1:0];
    assign w_err_dec  = (apb.PADDR[1:0] != 2'b00) ||
                        (w_idx_full >= IDXF_W'(NUM_REGS)) ||
                        (apb.PWRITE && (w_idx == ID_IDX || w_idx == ERRCNT_IDX));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_reg_rd = '0;
        if (w_idx == ID_IDX)
            w_reg_rd = ID_VALUE;
        else if (w_idx == WAIT_IDX)
            w_reg_rd = DATA_WIDTH'(r_wait_cfg);
        else if (w_idx == ERRCNT_IDX)
            w_reg_rd = DATA_WIDTH'(r_err_cnt);
        else
            w_reg_rd = r_scratch[w_idx];
    end

    assign w_rdata_dec = (w_err_dec || apb.PWRITE) ? '0 : w_reg_rd;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_setup) w_state_nxt = ACCESS;
            ACCESS:  if (w_abort || w_commit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_setup  = 1'b0;
        w_tick   = 1'b0;
        w_commit = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            IDLE: w_setup = apb.PSELx && !apb.PENABLE;
            ACCESS: begin
                w_abort  = !apb.PSELx;
                w_tick   = apb.PSELx && apb.PENABLE && !r_pready;
                w_commit = apb.PSELx && apb.PENABLE && r_pready;
            end
            default: ;
        endcase
    end

    apb_wait_timer #(.W(WAIT_W)) u_wait_timer (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .i_load     (w_setup),
        .i_load_val (r_wait_cfg),
        .i_en       (w_tick),
        .o_done     (w_tmr_done)
    );

    // Transfer capture and registered response
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else if (w_setup) begin
            r_idx     <= w_idx;
            r_write   <= apb.PWRITE;
            r_wdata   <= apb.PWDATA;
            r_err     <= w_err_dec;
            r_rdata   <= w_rdata_dec;
            r_pready  <= w_tmr_done;
            r_pslverr <= w_tmr_done && w_err_dec;
            r_prdata  <= w_tmr_done ? w_rdata_dec : '0;
        end else if (w_tick && w_tmr_done) begin
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= r_rdata;
        end else if (w_commit || w_abort) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end
    end

    // NOTE: the scratch array is small and must read 0 after reset, so it sits on the async reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait_cfg <= '0;
            r_err_cnt  <= '0;
            for (int i = SCRATCH_IDX; i < NUM_REGS; i++)
                r_scratch[i] <= '0;
        end else if (w_commit) begin
            if (r_err) begin
                if (r_err_cnt != '1)
                    r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end else if (r_write) begin
                if (r_idx == WAIT_IDX)
                    r_wait_cfg <= r_wdata[WAIT_W-1:0];
                else
                    r_scratch[r_idx] <= r_wdata;
            end
        end
    end

    assign apb.PREADY  = r_pready;
    assign apb.PSLVERR = r_pslverr;
    assign apb.PRDATA  = r_prdata;
endmodule
